// File: rtl/md_issue_ctrl.sv
// E-stage issue/stall controller for the multiply/divide unit: drives start/op/operands,
// predicts the unit's busy window cycle-exactly, stalls HI/LO consumers in D, requests rollback.
module md_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_md_op,
    input  logic [31:0] e_rs_val,
    input  logic [31:0] e_rt_val,
    input  logic        e_hold,
    input  logic        m_exc,
    input  logic        d_md_use,
    output logic        md_start,
    output logic [3:0]  md_op,
    output logic [31:0] md_d1,
    output logic [31:0] md_d2,
    output logic        md_err,
    output logic        stall_d,
    output logic        md_busy_pred
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_issued;
    logic             r_start_q;
    logic             w_op_start;
    logic             w_op_long;
    logic             w_op_mult;
    logic             w_run;

    assign w_op_start = (e_md_op >= 4'd1) && (e_md_op <= 4'd6);
    assign w_op_long  = (e_md_op >= 4'd1) && (e_md_op <= 4'd4);
    assign w_op_mult  = (e_md_op == 4'd1) || (e_md_op == 4'd2);
    assign w_run      = (r_state == ST_RUN);

    // An op arriving in E during RUN is a protocol violation; it is simply not started.
    assign md_start     = e_valid & w_op_start & ~r_issued & ~m_exc & ~w_run;
    assign md_op        = e_valid ? e_md_op : 4'd0;
    assign md_d1        = e_rs_val;
    assign md_d2        = e_rt_val;
    // The unit's own busy flag rises a cycle after start, so the start cycle is covered here.
    assign md_busy_pred = (md_start & w_op_long) | w_run;
    assign stall_d      = d_md_use & md_busy_pred;
    assign md_err       = m_exc & (r_start_q | r_issued);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (md_err) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_run) begin
            if (r_cnt == CNT_W'(1)) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
        end else if (md_start && w_op_long) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = w_op_mult ? MULT_CNT : DIV_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_issued  <= 1'b0;
            r_start_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_issued  <= ~m_exc & e_hold & (md_start | r_issued);
            r_start_q <= (md_start | r_issued) & ~e_hold & ~m_exc;
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenario tasks plus a randomized run
// checked against a cycle-timeline reference model.
module tb_md_issue_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [3:0]  e_md_op;
    logic [31:0] e_rs_val;
    logic [31:0] e_rt_val;
    logic        e_hold;
    logic        m_exc;
    logic        d_md_use;
    logic        md_start;
    logic [3:0]  md_op;
    logic [31:0] md_d1;
    logic [31:0] md_d2;
    logic        md_err;
    logic        stall_d;
    logic        md_busy_pred;

    int errors = 0;
    int checks = 0;

    md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op),
        .e_rs_val(e_rs_val), .e_rt_val(e_rt_val), .e_hold(e_hold), .m_exc(m_exc),
        .d_md_use(d_md_use), .md_start(md_start), .md_op(md_op), .md_d1(md_d1),
        .md_d2(md_d2), .md_err(md_err), .stall_d(stall_d), .md_busy_pred(md_busy_pred)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        e_valid  = 1'b0;
        e_md_op  = 4'd0;
        e_rs_val = 32'd0;
        e_rt_val = 32'd0;
        e_hold   = 1'b0;
        m_exc    = 1'b0;
        d_md_use = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #3;
        checks++;
        if ({md_start, md_err, stall_d, md_busy_pred} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: start/err/stall/busy=%b expected 0000",
                     {md_start, md_err, stall_d, md_busy_pred});
        end
        checks++;
        if (md_op !== 4'd0) begin
            errors++;
            $display("FAIL reset_md_op: got %0d expected 0", md_op);
        end
    endtask

    task automatic test_mult();
        int n_stall = 0, n_start = 0, last = -1;
        drain();
        e_valid = 1'b1; e_md_op = 4'd1; e_rs_val = 32'd7; e_rt_val = 32'hFFFF_FFFD; d_md_use = 1'b1;
        #3;
        checks++;
        if ({md_op, md_d1, md_d2} !== {4'd1, 32'd7, 32'hFFFF_FFFD}) begin
            errors++;
            $display("FAIL mult_operands: op=%0d d1=%h d2=%h expected op=1 d1=00000007 d2=fffffffd",
                     md_op, md_d1, md_d2);
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                tick();
                e_valid = 1'b0;
                #3;
            end
            if (stall_d) begin n_stall++; last = i; end
            if (md_start) n_start++;
        end
        checks++;
        if (n_start !== 1) begin
            errors++;
            $display("FAIL mult_start_pulses: got %0d expected 1", n_start);
        end
        checks++;
        if (n_stall !== MULT_LAT + 1 || last !== MULT_LAT) begin
            errors++;
            $display("FAIL mult_stall_window: got %0d cycles ending at %0d expected 6 ending at 5",
                     n_stall, last);
        end
    endtask

    task automatic test_divu_hold();
        int n_busy = 0, n_start = 0, last = -1;
        drain();
        e_rs_val = 32'd100; e_rt_val = 32'd7; d_md_use = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick();
            e_valid = (i <= 2);
            e_md_op = (i <= 2) ? 4'd4 : 4'd0;
            e_hold  = (i <= 1);
            #3;
            if (md_busy_pred) begin n_busy++; last = i; end
            if (md_start) n_start++;
        end
        checks++;
        if (n_start !== 1) begin
            errors++;
            $display("FAIL divu_hold_start_pulses: got %0d expected 1", n_start);
        end
        checks++;
        if (n_busy !== DIV_LAT + 1 || last !== DIV_LAT) begin
            errors++;
            $display("FAIL divu_hold_busy_window: got %0d cycles ending at %0d expected 11 ending at 10",
                     n_busy, last);
        end
    endtask

    task automatic test_long_hold();
        int n_start = 0;
        drain();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            e_valid = (i <= 8);
            e_md_op = 4'd2;
            e_hold  = (i <= 7);
            #3;
            if (md_start) n_start++;
        end
        checks++;
        if (n_start !== 1) begin
            errors++;
            $display("FAIL long_hold_no_restart: got %0d start pulses expected 1", n_start);
        end
    endtask

    task automatic test_run_suppress();
        int n_busy = 0;
        drain();
        e_valid = 1'b1; e_md_op = 4'd1;
        #3;
        if (md_busy_pred) n_busy++;
        tick();
        e_md_op = 4'd3;
        #3;
        if (md_busy_pred) n_busy++;
        checks++;
        if (md_start !== 1'b0) begin
            errors++;
            $display("FAIL run_suppress_start: got %b expected 0", md_start);
        end
        for (int i = 2; i < 14; i++) begin
            tick();
            e_valid = 1'b0;
            #3;
            if (md_busy_pred) n_busy++;
        end
        checks++;
        if (n_busy !== MULT_LAT + 1) begin
            errors++;
            $display("FAIL run_suppress_busy: got %0d busy cycles expected 6", n_busy);
        end
    endtask

    task automatic test_div_flush();
        drain();
        e_valid = 1'b1; e_md_op = 4'd3; d_md_use = 1'b1;
        #3;
        checks++;
        if ({md_start, md_busy_pred, stall_d} !== 3'b111) begin
            errors++;
            $display("FAIL div_flush_issue: start/busy/stall=%b expected 111",
                     {md_start, md_busy_pred, stall_d});
        end
        tick();
        e_valid = 1'b0; m_exc = 1'b1;
        #3;
        checks++;
        if ({md_err, stall_d} !== 2'b11) begin
            errors++;
            $display("FAIL div_flush_err: err/stall=%b expected 11", {md_err, stall_d});
        end
        tick();
        m_exc = 1'b0;
        #3;
        checks++;
        if ({md_err, stall_d, md_busy_pred} !== 3'b000) begin
            errors++;
            $display("FAIL div_flush_after: err/stall/busy=%b expected 000",
                     {md_err, stall_d, md_busy_pred});
        end
    endtask

    task automatic test_mthi_flush();
        drain();
        e_valid = 1'b1; e_md_op = 4'd5; e_rs_val = 32'h1234_5678; d_md_use = 1'b1;
        #3;
        checks++;
        if ({md_start, md_busy_pred, stall_d, md_d1} !== {3'b100, 32'h1234_5678}) begin
            errors++;
            $display("FAIL mthi_issue: start/busy/stall=%b d1=%h expected 100 12345678",
                     {md_start, md_busy_pred, stall_d}, md_d1);
        end
        tick();
        e_valid = 1'b0; m_exc = 1'b1;
        #3;
        checks++;
        if ({md_err, md_busy_pred} !== 2'b10) begin
            errors++;
            $display("FAIL mthi_flush_err: err/busy=%b expected 10", {md_err, md_busy_pred});
        end
        tick();
        m_exc = 1'b0;
        #3;
        checks++;
        if (md_err !== 1'b0) begin
            errors++;
            $display("FAIL mthi_flush_after: err=%b expected 0", md_err);
        end
    endtask

    task automatic test_late_exc();
        int n_busy = 0, n_err = 0;
        drain();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            e_valid = (i == 0);
            e_md_op = (i == 0) ? 4'd1 : 4'd0;
            m_exc   = (i == 3);
            #3;
            if (md_busy_pred) n_busy++;
            if (md_err) n_err++;
        end
        checks++;
        if (n_err !== 0 || n_busy !== MULT_LAT + 1) begin
            errors++;
            $display("FAIL late_exc: err cycles=%0d busy cycles=%0d expected 0 and 6", n_err, n_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        drain();
        e_valid = 1'b1; e_md_op = 4'd3; d_md_use = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            e_valid = 1'b0;
        end
        #3;
        checks++;
        if (md_busy_pred !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_run_busy_before: got %b expected 1", md_busy_pred);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; e_valid = 1'b1; e_md_op = 4'd8;
        #3;
        checks++;
        if ({md_start, md_busy_pred, stall_d} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_run_after: start/busy/stall=%b expected 000",
                     {md_start, md_busy_pred, stall_d});
        end
        tick();
        e_md_op = 4'd1;
        #3;
        checks++;
        if (md_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_run_restart: start=%b expected 1", md_start);
        end
    endtask

    // Reference model: a timeline of when the predicted busy window ends, plus the pipeline
    // position (held in E / sitting in M) of the most recently started instruction.
    task automatic test_random();
        int  t = 0;
        int  busy_end = 0;
        bit  held = 1'b0;
        bit  in_m = 1'b0;
        bit  running, start_op, long_op, e_start, e_busy, e_err;
        logic [3:0] e_op_out;
        drain();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            tick();
            t++;
            reset    = ($urandom_range(0, 199) == 0);
            e_valid  = ($urandom_range(0, 3) != 0);
            e_md_op  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(1, 8));
            e_rs_val = $urandom;
            e_rt_val = $urandom;
            e_hold   = ($urandom_range(0, 3) == 0);
            m_exc    = ($urandom_range(0, 11) == 0);
            d_md_use = $urandom_range(0, 1);
            #3;
            running  = (t < busy_end);
            start_op = (e_md_op >= 1 && e_md_op <= 6);
            long_op  = (e_md_op >= 1 && e_md_op <= 4);
            e_start  = e_valid && start_op && !held && !m_exc && !running;
            e_busy   = (e_start && long_op) || running;
            e_err    = m_exc && (in_m || held);
            e_op_out = e_valid ? e_md_op : 4'd0;
            checks++;
            if (md_start !== e_start) begin
                errors++;
                $display("FAIL rand_start t=%0d: got %b expected %b", t, md_start, e_start);
            end
            checks++;
            if (md_busy_pred !== e_busy) begin
                errors++;
                $display("FAIL rand_busy t=%0d: got %b expected %b", t, md_busy_pred, e_busy);
            end
            checks++;
            if (stall_d !== (d_md_use && e_busy)) begin
                errors++;
                $display("FAIL rand_stall t=%0d: got %b expected %b", t, stall_d, d_md_use && e_busy);
            end
            checks++;
            if (md_err !== e_err) begin
                errors++;
                $display("FAIL rand_err t=%0d: got %b expected %b", t, md_err, e_err);
            end
            checks++;
            if ({md_op, md_d1, md_d2} !== {e_op_out, e_rs_val, e_rt_val}) begin
                errors++;
                $display("FAIL rand_passthru t=%0d: op=%0d d1=%h d2=%h expected op=%0d d1=%h d2=%h",
                         t, md_op, md_d1, md_d2, e_op_out, e_rs_val, e_rt_val);
            end
            if (reset) begin
                busy_end = t + 1;
                held     = 1'b0;
                in_m     = 1'b0;
            end else begin
                if (e_err && busy_end > t + 1) busy_end = t + 1;
                else if (e_start && long_op)
                    busy_end = t + 1 + ((e_md_op <= 2) ? MULT_LAT : DIV_LAT);
                in_m = (e_start || held) && !e_hold && !m_exc;
                held = (e_start || held) && e_hold && !m_exc;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_mult();
        test_divu_hold();
        test_long_hold();
        test_run_suppress();
        test_div_flush();
        test_mthi_flush();
        test_late_exc();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
